// File: rtl/karaoke_pkg.sv
// Shared definitions for the karaoke scoring blocks: grade codes, scorer FSM
// states and default frequency settings.
package karaoke_pkg;

    typedef enum logic [1:0] {
        GRADE_MISS    = 2'd0,
        GRADE_GOOD    = 2'd1,
        GRADE_PERFECT = 2'd2,
        GRADE_REST    = 2'd3
    } grade_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CLASS = 2'd2,
        S_ACCUM = 2'd3
    } state_e;

    localparam int FREQ_WIDTH_DEF = 16;
    localparam int MIN_FREQ_DEF   = 50;

endpackage

// File: rtl/pitch_classifier.sv
// Combinational pitch grader: absolute frequency error against shift-derived
// tolerance bands, with rest and silence detection.
module pitch_classifier
    import karaoke_pkg::*;
#(
    parameter int FREQ_WIDTH    = FREQ_WIDTH_DEF,
    parameter int PERFECT_SHIFT = 5,
    parameter int GOOD_SHIFT    = 3,
    parameter int MIN_FREQ      = MIN_FREQ_DEF
) (
    input  logic [FREQ_WIDTH-1:0] i_mic,
    input  logic [FREQ_WIDTH-1:0] i_target,
    output logic [1:0]            o_grade
);

    localparam logic [FREQ_WIDTH-1:0] MIN_F = FREQ_WIDTH'(MIN_FREQ);

    logic [FREQ_WIDTH:0] w_diff;
    logic [FREQ_WIDTH:0] w_tol_perfect;
    logic [FREQ_WIDTH:0] w_tol_good;

    assign w_diff = (i_mic >= i_target) ? ({1'b0, i_mic} - {1'b0, i_target})
                                        : ({1'b0, i_target} - {1'b0, i_mic});
    assign w_tol_perfect = {1'b0, i_target >> PERFECT_SHIFT};
    assign w_tol_good    = {1'b0, i_target >> GOOD_SHIFT};

    always_comb begin
        o_grade = GRADE_MISS;
        if (i_target == '0) begin
            o_grade = GRADE_REST;
        end else if (i_mic < MIN_F) begin
            o_grade = GRADE_MISS;
        end else if (w_diff <= w_tol_perfect) begin
            o_grade = GRADE_PERFECT;
        end else if (w_diff <= w_tol_good) begin
            o_grade = GRADE_GOOD;
        end
    end

endmodule

// File: rtl/pitch_scorer.sv
// Game scorer: latches each mic sample, grades it against the target note and
// accumulates a saturating score with a streak bonus.
module pitch_scorer
    import karaoke_pkg::*;
#(
    parameter int FREQ_WIDTH       = FREQ_WIDTH_DEF,
    parameter int SCORE_WIDTH      = 16,
    parameter int PERFECT_SHIFT    = 5,
    parameter int GOOD_SHIFT       = 3,
    parameter int PERFECT_POINTS   = 10,
    parameter int GOOD_POINTS      = 4,
    parameter int STREAK_BONUS_LEN = 4,
    parameter int MIN_FREQ         = MIN_FREQ_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [FREQ_WIDTH-1:0]  mic_freq,
    input  logic                   mic_valid,
    input  logic [FREQ_WIDTH-1:0]  target_freq,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [7:0]             streak,
    output logic [1:0]             grade,
    output logic                   grade_valid,
    output logic                   active,
    output logic                   overrun
);

    localparam logic [SCORE_WIDTH:0] PERF_PTS  = (SCORE_WIDTH+1)'(PERFECT_POINTS);
    localparam logic [SCORE_WIDTH:0] GOOD_PTS  = (SCORE_WIDTH+1)'(GOOD_POINTS);
    localparam logic [7:0]           BONUS_LEN = 8'(STREAK_BONUS_LEN);

    state_e                 r_state;
    logic [FREQ_WIDTH-1:0]  r_mic;
    logic [FREQ_WIDTH-1:0]  r_target;
    logic [1:0]             r_class;
    logic [SCORE_WIDTH-1:0] r_score;
    logic [7:0]             r_streak;
    logic [1:0]             r_grade;
    logic                   r_grade_valid;
    logic                   r_active;
    logic                   r_overrun;

    logic [1:0]             w_class;
    logic                   w_hit;
    logic [SCORE_WIDTH:0]   w_base;
    logic [SCORE_WIDTH:0]   w_points;
    logic [SCORE_WIDTH:0]   w_sum;
    logic [SCORE_WIDTH-1:0] w_score_next;

    pitch_classifier #(
        .FREQ_WIDTH   (FREQ_WIDTH),
        .PERFECT_SHIFT(PERFECT_SHIFT),
        .GOOD_SHIFT   (GOOD_SHIFT),
        .MIN_FREQ     (MIN_FREQ)
    ) u_classifier (
        .i_mic   (r_mic),
        .i_target(r_target),
        .o_grade (w_class)
    );

    // Bonus is judged on the streak before this sample is counted.
    assign w_hit    = (r_class == GRADE_PERFECT) || (r_class == GRADE_GOOD);
    assign w_base   = (r_class == GRADE_PERFECT) ? PERF_PTS :
                      (r_class == GRADE_GOOD)    ? GOOD_PTS : '0;
    assign w_points = (r_streak >= BONUS_LEN) ? (w_base << 1) : w_base;
    assign w_sum    = {1'b0, r_score} + w_points;
    assign w_score_next = w_sum[SCORE_WIDTH] ? '1 : w_sum[SCORE_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_mic         <= '0;
            r_target      <= '0;
            r_class       <= '0;
            r_score       <= '0;
            r_streak      <= '0;
            r_grade       <= '0;
            r_grade_valid <= 1'b0;
            r_active      <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_grade_valid <= 1'b0;
            if (start) begin
                r_state   <= S_WAIT;
                r_active  <= 1'b1;
                r_score   <= '0;
                r_streak  <= '0;
                r_grade   <= '0;
                r_overrun <= 1'b0;
            end else if (stop) begin
                r_state  <= S_IDLE;
                r_active <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_active <= 1'b0;
                    end
                    S_WAIT: begin
                        if (mic_valid) begin
                            r_mic    <= mic_freq;
                            r_target <= target_freq;
                            r_state  <= S_CLASS;
                        end
                    end
                    S_CLASS: begin
                        r_class <= w_class;
                        r_state <= S_ACCUM;
                        if (mic_valid) r_overrun <= 1'b1;
                    end
                    S_ACCUM: begin
                        r_score       <= w_score_next;
                        r_grade       <= r_class;
                        r_grade_valid <= 1'b1;
                        r_state       <= S_WAIT;
                        if (mic_valid) r_overrun <= 1'b1;
                        if (w_hit) begin
                            if (r_streak != 8'hFF) r_streak <= r_streak + 8'd1;
                        end else if (r_class == GRADE_MISS) begin
                            r_streak <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign score       = r_score;
    assign streak      = r_streak;
    assign grade       = r_grade;
    assign grade_valid = r_grade_valid;
    assign active      = r_active;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_pitch_scorer.sv
// Directed bench for pitch_scorer: a default-width instance and an 8-bit score
// instance share all stimulus so saturation can be seen next to the wide score.
module tb_pitch_scorer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] mic_freq = '0;
    logic        mic_valid = 1'b0;
    logic [15:0] target_freq = '0;

    logic [15:0] score;
    logic [7:0]  streak;
    logic [1:0]  grade;
    logic        gv;
    logic        active;
    logic        overrun;

    logic [7:0]  score8;
    logic [7:0]  streak8;
    logic [1:0]  grade8;
    logic        gv8;
    logic        active8;
    logic        overrun8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pitch_scorer dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .mic_freq(mic_freq), .mic_valid(mic_valid), .target_freq(target_freq),
        .score(score), .streak(streak), .grade(grade), .grade_valid(gv),
        .active(active), .overrun(overrun)
    );

    pitch_scorer #(.SCORE_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .mic_freq(mic_freq), .mic_valid(mic_valid), .target_freq(target_freq),
        .score(score8), .streak(streak8), .grade(grade8), .grade_valid(gv8),
        .active(active8), .overrun(overrun8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Pulses mic_valid once; lat is the tick on which grade_valid rose, or -1.
    task automatic send(input logic [15:0] m, input logic [15:0] t, output int lat);
        mic_freq = m;
        target_freq = t;
        mic_valid = 1'b1;
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            mic_valid = 1'b0;
            if (gv === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_gv(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            mic_valid = 1'b0;
            if (gv === 1'b1) cnt++;
        end
    endtask

    task automatic test_reset();
        int lat;
        int cnt;
        reset = 1'b1;
        tick();
        tick();
        n_vec++; if (score !== 16'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", score); end
        n_vec++; if (streak !== 8'd0) begin n_err++; $display("FAIL reset_streak: got %0d want 0", streak); end
        n_vec++; if (grade !== 2'd0) begin n_err++; $display("FAIL reset_grade: got %0d want 0", grade); end
        n_vec++; if (gv !== 1'b0) begin n_err++; $display("FAIL reset_gv: got %b want 0", gv); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        reset = 1'b0;
        tick();

        do_start();
        send(16'd440, 16'd440, lat);
        n_vec++; if (score !== 16'd10) begin n_err++; $display("FAIL premid_score: got %0d want 10", score); end
        mic_valid = 1'b1;
        tick();
        mic_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_vec++; if (score !== 16'd0) begin n_err++; $display("FAIL midreset_score: got %0d want 0", score); end
        n_vec++; if (streak !== 8'd0) begin n_err++; $display("FAIL midreset_streak: got %0d want 0", streak); end
        n_vec++; if (grade !== 2'd0) begin n_err++; $display("FAIL midreset_grade: got %0d want 0", grade); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL midreset_active: got %b want 0", active); end
        tick();
        reset = 1'b0;
        count_gv(4, cnt);
        n_vec++; if (cnt !== 0) begin n_err++; $display("FAIL midreset_no_gv: got %0d want 0", cnt); end
        mic_freq = 16'd440;
        target_freq = 16'd440;
        mic_valid = 1'b1;
        count_gv(5, cnt);
        n_vec++; if (cnt !== 0) begin n_err++; $display("FAIL idle_ignore_gv: got %0d want 0", cnt); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL idle_active: got %b want 0", active); end
        n_vec++; if (score !== 16'd0) begin n_err++; $display("FAIL idle_score: got %0d want 0", score); end
    endtask

    task automatic test_bands();
        logic [15:0] mics [5] = '{16'd440, 16'd453, 16'd495, 16'd496, 16'd30};
        logic [1:0]  grds [5] = '{2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
        logic [15:0] scs  [5] = '{16'd10, 16'd20, 16'd24, 16'd24, 16'd24};
        logic [7:0]  sks  [5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0};
        int lat;
        do_start();
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL start_active: got %b want 1", active); end
        for (int i = 0; i < 5; i++) begin
            send(mics[i], 16'd440, lat);
            n_vec++; if (lat !== 3) begin n_err++; $display("FAIL band%0d_latency: got %0d want 3", i, lat); end
            n_vec++; if (grade !== grds[i]) begin n_err++; $display("FAIL band%0d_grade: got %0d want %0d", i, grade, grds[i]); end
            n_vec++; if (score !== scs[i]) begin n_err++; $display("FAIL band%0d_score: got %0d want %0d", i, score, scs[i]); end
            n_vec++; if (streak !== sks[i]) begin n_err++; $display("FAIL band%0d_streak: got %0d want %0d", i, streak, sks[i]); end
        end
    endtask

    task automatic test_streak_bonus();
        logic [15:0] scs [6] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd60, 16'd80};
        int lat;
        do_start();
        for (int i = 0; i < 6; i++) begin
            send(16'd440, 16'd440, lat);
            n_vec++; if (lat !== 3) begin n_err++; $display("FAIL bonus%0d_latency: got %0d want 3", i, lat); end
            n_vec++; if (score !== scs[i]) begin n_err++; $display("FAIL bonus%0d_score: got %0d want %0d", i, score, scs[i]); end
        end
        n_vec++; if (streak !== 8'd6) begin n_err++; $display("FAIL bonus_streak: got %0d want 6", streak); end
        tick();
        n_vec++; if (gv !== 1'b0) begin n_err++; $display("FAIL bonus_gv_pulse: got %b want 0", gv); end
    endtask

    task automatic test_rest_silence();
        int lat;
        do_start();
        for (int i = 0; i < 3; i++) send(16'd440, 16'd440, lat);
        send(16'd440, 16'd0, lat);
        n_vec++; if (grade !== 2'd3) begin n_err++; $display("FAIL rest_grade: got %0d want 3", grade); end
        n_vec++; if (score !== 16'd30) begin n_err++; $display("FAIL rest_score: got %0d want 30", score); end
        n_vec++; if (streak !== 8'd3) begin n_err++; $display("FAIL rest_streak: got %0d want 3", streak); end
        send(16'd0, 16'd440, lat);
        n_vec++; if (grade !== 2'd0) begin n_err++; $display("FAIL silence_grade: got %0d want 0", grade); end
        n_vec++; if (streak !== 8'd0) begin n_err++; $display("FAIL silence_streak: got %0d want 0", streak); end
        n_vec++; if (score !== 16'd30) begin n_err++; $display("FAIL silence_score: got %0d want 30", score); end
    endtask

    task automatic test_saturation();
        int lat;
        do_start();
        for (int i = 0; i < 14; i++) send(16'd440, 16'd440, lat);
        n_vec++; if (score8 !== 8'd240) begin n_err++; $display("FAIL sat_240: got %0d want 240", score8); end
        send(16'd496, 16'd440, lat);
        send(16'd440, 16'd440, lat);
        n_vec++; if (score8 !== 8'd250) begin n_err++; $display("FAIL sat_250: got %0d want 250", score8); end
        send(16'd440, 16'd440, lat);
        n_vec++; if (score8 !== 8'd255) begin n_err++; $display("FAIL sat_clamp1: got %0d want 255", score8); end
        n_vec++; if (score !== 16'd260) begin n_err++; $display("FAIL sat_wide1: got %0d want 260", score); end
        send(16'd440, 16'd440, lat);
        n_vec++; if (score8 !== 8'd255) begin n_err++; $display("FAIL sat_clamp2: got %0d want 255", score8); end
        n_vec++; if (score !== 16'd270) begin n_err++; $display("FAIL sat_wide2: got %0d want 270", score); end

        do_start();
        for (int i = 0; i < 260; i++) send(16'd440, 16'd440, lat);
        n_vec++; if (streak8 !== 8'd255) begin n_err++; $display("FAIL streak_sat: got %0d want 255", streak8); end
        n_vec++; if (streak !== 8'd255) begin n_err++; $display("FAIL streak_sat_wide: got %0d want 255", streak); end
        n_vec++; if (score8 !== 8'd255) begin n_err++; $display("FAIL streak_sat_score8: got %0d want 255", score8); end
        n_vec++; if (score !== 16'd5160) begin n_err++; $display("FAIL streak_sat_score: got %0d want 5160", score); end
    endtask

    task automatic test_overrun();
        int cnt;
        do_start();
        mic_freq = 16'd440;
        target_freq = 16'd440;
        mic_valid = 1'b1;
        tick();
        mic_freq = 16'd30;
        tick();
        mic_valid = 1'b0;
        tick();
        n_vec++; if (gv !== 1'b1) begin n_err++; $display("FAIL ovr_gv: got %b want 1", gv); end
        n_vec++; if (grade !== 2'd2) begin n_err++; $display("FAIL ovr_grade: got %0d want 2", grade); end
        n_vec++; if (score !== 16'd10) begin n_err++; $display("FAIL ovr_score: got %0d want 10", score); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        count_gv(5, cnt);
        n_vec++; if (cnt !== 0) begin n_err++; $display("FAIL ovr_dropped: got %0d want 0", cnt); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        do_start();
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_stop();
        int lat;
        int cnt;
        do_start();
        send(16'd440, 16'd440, lat);
        mic_valid = 1'b1;
        tick();
        mic_valid = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_vec++; if (gv !== 1'b0) begin n_err++; $display("FAIL stop_gv: got %b want 0", gv); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL stop_active: got %b want 0", active); end
        n_vec++; if (score !== 16'd10) begin n_err++; $display("FAIL stop_score: got %0d want 10", score); end
        n_vec++; if (streak !== 8'd1) begin n_err++; $display("FAIL stop_streak: got %0d want 1", streak); end
        mic_valid = 1'b1;
        count_gv(5, cnt);
        n_vec++; if (cnt !== 0) begin n_err++; $display("FAIL stop_idle_gv: got %0d want 0", cnt); end
    endtask

    task automatic test_start_stop();
        int lat;
        do_start();
        mic_freq = 16'd440;
        target_freq = 16'd440;
        mic_valid = 1'b1;
        tick();
        tick();
        mic_valid = 1'b0;
        tick();
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ss_pre_overrun: got %b want 1", overrun); end
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL ss_active: got %b want 1", active); end
        n_vec++; if (score !== 16'd0) begin n_err++; $display("FAIL ss_score: got %0d want 0", score); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ss_overrun: got %b want 0", overrun); end
        send(16'd440, 16'd440, lat);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL ss_latency: got %0d want 3", lat); end
        n_vec++; if (score !== 16'd10) begin n_err++; $display("FAIL ss_score_after: got %0d want 10", score); end
    endtask

    initial begin
        test_reset();
        test_bands();
        test_streak_bonus();
        test_rest_silence();
        test_saturation();
        test_overrun();
        test_stop();
        test_start_stop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/pitch_scorer.md
Name: pitch_scorer

Overview:
Downstream consumer of the microphone frequency meter. It takes each new measured mic frequency, compares it against the current target note frequency from the song sequencer, and classifies the sample as PERFECT, GOOD, MISS or REST. It accumulates a saturating game score with a streak bonus. Its outputs drive the score display and the per-note feedback LEDs.

Parameters:
FREQ_WIDTH, 16, width of mic and target frequencies (Hz)
SCORE_WIDTH, 16, width of score accumulator
PERFECT_SHIFT, 5, perfect tolerance = target >> PERFECT_SHIFT
GOOD_SHIFT, 3, good tolerance = target >> GOOD_SHIFT
PERFECT_POINTS, 10, points for PERFECT
GOOD_POINTS, 4, points for GOOD
STREAK_BONUS_LEN, 4, prior streak length at or above which points are doubled
MIN_FREQ, 50, mic_freq below this counts as silence (MISS)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: clear score and begin scoring
stop  input  1  one-cycle pulse: end scoring and hold the score
mic_freq  input  FREQ_WIDTH  measured frequency from the frequency meter
mic_valid  input  1  one-cycle strobe: mic_freq has a new value
target_freq  input  FREQ_WIDTH  current note frequency; 0 = rest
score  output  SCORE_WIDTH  accumulated score
streak  output  8  consecutive PERFECT/GOOD count
grade  output  2  0=MISS, 1=GOOD, 2=PERFECT, 3=REST
grade_valid  output  1  one-cycle pulse when grade, score and streak update
active  output  1  high while scoring
overrun  output  1  sticky: mic_valid arrived while busy; cleared by start

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-high.
- Reset: state IDLE; score=0, streak=0, grade=0, grade_valid=0, active=0, overrun=0.
- States:
  - IDLE: active=0; mic_valid ignored.
  - WAIT: active=1; mic_valid=1 latches mic_freq and target_freq, then goes to CLASS.
  - CLASS: registered classification; goes to ACCUM.
  - ACCUM: updates score/streak/grade; grade_valid=1 for exactly this cycle; returns to WAIT.
- Latency: mic_valid sampled at edge k gives grade_valid high in the cycle after edge k+2. The updated score/streak/grade are visible in that same cycle.
- mic_valid while in CLASS or ACCUM: sample dropped, overrun set to 1 (sticky).
- Classification uses diff = |mic - target|, computed at FREQ_WIDTH+1 bits:
  - target==0 → REST.
  - mic < MIN_FREQ → MISS.
  - diff <= target>>PERFECT_SHIFT → PERFECT.
  - diff <= target>>GOOD_SHIFT → GOOD.
  - otherwise MISS.
  - Comparisons are inclusive.
- Points: PERFECT_POINTS or GOOD_POINTS, doubled if streak (before update) >= STREAK_BONUS_LEN. MISS and REST give 0.
- Score: saturating add; clamps at 2^SCORE_WIDTH-1 and never wraps.
- Streak:
  - PERFECT/GOOD → +1, saturating at 255.
  - MISS → 0.
  - REST → unchanged.
- start (any state): next cycle score=0, streak=0, grade=0, overrun=0; state WAIT. Any in-flight sample is discarded.
- stop (any state): state IDLE; score/streak/grade hold. A sample in CLASS/ACCUM is aborted and no grade_valid is produced.
- start and stop in the same cycle: start wins.
- Reset mid-operation: immediate return to reset values; no grade_valid.

Decomposition:
- Shared package karaoke_pkg:
  - grade encodings GRADE_MISS/GOOD/PERFECT/REST;
  - FSM state encodings;
  - default FREQ_WIDTH;
  - MIN_FREQ.
- One sub-module, pitch_classifier: combinational abs-diff plus threshold compare, producing a 2-bit grade. It is instantiated in the CLASS stage and reusable by the future multi-player scorer.

Test Plan:
- Reset asserted during CLASS after start plus one mic_valid → no grade_valid; all outputs 0; active=0; later mic_valid ignored until start.
- Tolerance bands with target=440: mic 440 → PERFECT, score 10, streak 1; mic 453 (diff 13) → PERFECT, score 20; mic 495 (diff 55) → GOOD, score 24; mic 496 → MISS, streak 0, score 24; mic 30 → MISS.
- Streak bonus with target=440, mic=440 ×6 → scores 10, 20, 30, 40, 60, 80; streak 6. grade_valid is exactly 2 clocks after each sampled mic_valid.
- Rest and silence: target 0 with streak 3 → grade 3, score unchanged, streak stays 3. Then target 440, mic 0 → MISS, streak 0.
- Saturation with SCORE_WIDTH=8: from score 250, a PERFECT → 255. A further PERFECT → 255. Streak saturates at 255 after 260 hits.
- Control edge cases:
  - mic_valid during CLASS → overrun=1, first sample still graded, second dropped.
  - stop during ACCUM-entry → no grade_valid, score held.
  - start+stop same cycle → active=1, score 0, overrun 0.
